crc_req_seq_n: RTL and testbench
================================

// Module: crc_req_seq_n
// PURPOSE
//  Parametrised channel request/cycle sequencer for the channel-control logic.
//  Generalises the single-channel request, activity counter and RAM/MB cycle
//  control to NCH channels, each with its own activity counter.
//  Arbitrates channel requests round-robin and runs one RAM cycle, then one
//  MB cycle per grant. Adds overflow flags and an MB-acknowledge timeout.
// PARAMETERS
//  NCH     8   number of channels (2..16)
//  CTRW    3   width of each per-channel activity counter
//  RAMCYC  2   clocks that crc_ram_cyc_l is held asserted per grant (>=1)
//  MBTMO   15  clocks allowed for mb_cyc_t2_l after MB cycle start (>=2)
// PORTS
//  clk_crc_h          in   1         block clock; all state changes on its rising edge
//  ch_mr_reset_l      in   1         master reset, synchronous, active-low
//  ch_req_h           in   NCH       per-channel service request (level)
//  ch_store_h         in   NCH       1 = granted cycle is a memory store
//  ch_act_inc_h       in   NCH       pulse: queue one transfer (counter +1)
//  ch_err_clr_h       in   1         clears crc_ovn_err_h and crc_mb_tmo_h
//  mb_cyc_t2_l        in   1         MB cycle T2 acknowledge, active-low
//  crc_grant_h        out  NCH       one-hot grant; held from RAM through DONE
//  crc_ram_cyc_l      out  1         RAM cycle in progress, active-low
//  crc_mb_cyc_h       out  1         MB cycle in progress
//  crc_mem_store_ena_l out 1         low during MB when granted channel stores
//  crc_act_ctr_h      out  NCH*CTRW  activity counters; channel i at [i*CTRW +: CTRW]
//  crc_ovn_err_h      out  NCH       sticky per-channel counter overflow
//  crc_mb_tmo_h       out  1         sticky MB acknowledge timeout
//  crc_busy_h         out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset (ch_mr_reset_l low at an edge): FSM=IDLE, grants 0, counters 0.
//   Flags 0, round-robin pointer = NCH-1, crc_ram_cyc_l=1, crc_mem_store_ena_l=1,
//   crc_mb_cyc_h=0. Reset wins over every other input, including mid-cycle.
//  Eligible channel i: ch_req_h[i]=1 and counter[i]!=0.
//  FSM states:
//   IDLE: if any channel is eligible, grant the first one scanning ptr+1, ptr+2, ...
//    (modulo NCH). Next state is RAM; the grant is visible the next clock.
//   RAM: crc_ram_cyc_l=0 for exactly RAMCYC clocks, then MB.
//   MB: crc_mb_cyc_h=1 and the timeout counter runs. mb_cyc_t2_l=0 -> DONE.
//    If MBTMO clocks elapse first: set crc_mb_tmo_h and go to IDLE.
//    The counter is not decremented and the pointer is unchanged.
//   DONE: one clock. Decrement the granted counter, set ptr = granted index, go IDLE.
//  A grant is latched at entry to RAM. Dropping ch_req_h mid-sequence does not abort.
//  crc_mem_store_ena_l = ~(MB & ch_store_h[granted]), sampled live during MB.
//  Counter update per channel, evaluated in the same edge:
//   inc only: +1, or saturate at 2^CTRW-1 and set crc_ovn_err_h[i].
//   dec only: -1.
//   inc and dec together: count unchanged, no overflow.
//  ch_err_clr_h clears both flag types. A set in the same clock wins over the clear.
//  Minimum sequence is RAMCYC+3 clocks (IDLE, RAM x RAMCYC, MB, DONE).
//   The next grant can be issued in the IDLE clock that follows DONE.
// TESTING
//  1. Reset, inc ch2 once, req ch2 -> grant[2] for RAMCYC+2 clks; ram_cyc_l low 2 clks.
//     With T2 at MB clock 1: ctr2 0 after DONE, busy drops.
//  2. ch0, ch3, ch5 each ctr=1 and requesting, ptr=7 -> grants 0, 3, 5 in that order.
//     Re-arm all three -> next order is 0, 3, 5 again.
//  3. 8 incs on ch1 with CTRW=3 -> ctr1=7, ovn_err[1]=1.
//     Inc and dec in the same clock at ctr=7 -> stays 7, flag unchanged.
//  4. Hold mb_cyc_t2_l=1 -> after 15 MB clocks mb_tmo=1, FSM IDLE, counter unchanged.
//     ch_err_clr_h -> flag 0.
//  5. ch_store_h=1 on granted ch -> mem_store_ena_l low only during MB.
//     Assert reset during MB -> all outputs at reset values the next clock.
//  6. ch_req_h high but ctr=0 -> no grant, busy stays 0.

Source files
------------

// File: rtl/crc_req_seq_n.sv
// Multi-channel request/cycle sequencer: round-robin grant among channels with
// pending work, then one RAM cycle and one MB cycle per grant.
module crc_req_seq_n #(
  parameter int NCH    = 8,
  parameter int CTRW   = 3,
  parameter int RAMCYC = 2,
  parameter int MBTMO  = 15
) (
  input  logic                clk_crc_h,
  input  logic                ch_mr_reset_l,
  input  logic [NCH-1:0]      ch_req_h,
  input  logic [NCH-1:0]      ch_store_h,
  input  logic [NCH-1:0]      ch_act_inc_h,
  input  logic                ch_err_clr_h,
  input  logic                mb_cyc_t2_l,
  output logic [NCH-1:0]      crc_grant_h,
  output logic                crc_ram_cyc_l,
  output logic                crc_mb_cyc_h,
  output logic                crc_mem_store_ena_l,
  output logic [NCH*CTRW-1:0] crc_act_ctr_h,
  output logic [NCH-1:0]      crc_ovn_err_h,
  output logic                crc_mb_tmo_h,
  output logic                crc_busy_h
);

  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TMAX = (RAMCYC > MBTMO) ? RAMCYC : MBTMO;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RAM, S_MB, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     gidx_q, gidx_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [CTRW-1:0]     ctr_q [NCH];
  logic [CTRW-1:0]     ctr_d [NCH];
  logic [NCH-1:0]      ovn_q, ovn_d, ovn_set;
  logic                tmo_q, tmo_d, tmo_set;
  logic [NCH-1:0]      elig, dec_vec;
  logic [IDXW-1:0]     scan_idx, pick_idx;
  logic                pick_found;

  // Round-robin search starting just after the last serviced channel
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = ch_req_h[i] && (ctr_q[i] != '0);
    end
    for (int k = 1; k <= NCH; k++) begin
      scan_idx = IDXW'((int'(ptr_q) + k) % NCH);
      if (!pick_found && elig[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    dec_vec = '0;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          tmr_d   = '0;
          state_d = S_RAM;
        end
      end
      S_RAM: begin
        if (tmr_q == TW'(RAMCYC - 1)) begin
          tmr_d   = '0;
          state_d = S_MB;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_MB: begin
        if (!mb_cyc_t2_l) begin
          state_d = S_DONE;
        end else if (tmr_q == TW'(MBTMO - 1)) begin
          // Abandon the transfer: counter and pointer stay as they were
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
        dec_vec[gidx_q] = 1'b1;
        ptr_d           = gidx_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Simultaneous queue and completion cancel out without touching the flag
  always_comb begin
    ovn_set = '0;
    for (int i = 0; i < NCH; i++) begin
      ctr_d[i] = ctr_q[i];
      case ({ch_act_inc_h[i], dec_vec[i]})
        2'b10: begin
          if (ctr_q[i] == {CTRW{1'b1}}) ovn_set[i] = 1'b1;
          else ctr_d[i] = ctr_q[i] + CTRW'(1);
        end
        2'b01:   ctr_d[i] = ctr_q[i] - CTRW'(1);
        default: ctr_d[i] = ctr_q[i];
      endcase
    end
    ovn_d = (ch_err_clr_h ? '0 : ovn_q) | ovn_set;
    tmo_d = (ch_err_clr_h ? 1'b0 : tmo_q) | tmo_set;
  end

  always_ff @(posedge clk_crc_h) begin
    if (!ch_mr_reset_l) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      ptr_q   <= IDXW'(NCH - 1);
      tmr_q   <= '0;
      ovn_q   <= '0;
      tmo_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) ctr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      ovn_q   <= ovn_d;
      tmo_q   <= tmo_d;
      for (int i = 0; i < NCH; i++) ctr_q[i] <= ctr_d[i];
    end
  end

  always_comb begin
    crc_act_ctr_h = '0;
    for (int i = 0; i < NCH; i++) crc_act_ctr_h[i*CTRW +: CTRW] = ctr_q[i];
  end

  assign crc_grant_h         = (state_q != S_IDLE) ? (NCH'(1) << gidx_q) : '0;
  assign crc_ram_cyc_l       = (state_q != S_RAM);
  assign crc_mb_cyc_h        = (state_q == S_MB);
  assign crc_mem_store_ena_l = ~((state_q == S_MB) && ch_store_h[gidx_q]);
  assign crc_ovn_err_h       = ovn_q;
  assign crc_mb_tmo_h        = tmo_q;
  assign crc_busy_h          = (state_q != S_IDLE);

endmodule

// File: tb/tb_crc_req_seq_n.sv
// Bench for crc_req_seq_n: directed vector table, hand sequences for the
// multi-cycle cases, and random traffic against a transaction-level model.
module tb_crc_req_seq_n;
  localparam int NCH = 8, CTRW = 3, RAMCYC = 2, MBTMO = 15;
  localparam int CMAX = (1 << CTRW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, clr, t2_l;
  logic [NCH-1:0]      req, store, inc;
  logic [NCH-1:0]      grant, ovn;
  logic                ram_l, mb, store_l, tmo, busy;
  logic [NCH*CTRW-1:0] ctr;

  crc_req_seq_n #(.NCH(NCH), .CTRW(CTRW), .RAMCYC(RAMCYC), .MBTMO(MBTMO)) dut (
    .clk_crc_h(clk), .ch_mr_reset_l(rst_n), .ch_req_h(req), .ch_store_h(store),
    .ch_act_inc_h(inc), .ch_err_clr_h(clr), .mb_cyc_t2_l(t2_l),
    .crc_grant_h(grant), .crc_ram_cyc_l(ram_l), .crc_mb_cyc_h(mb),
    .crc_mem_store_ena_l(store_l), .crc_act_ctr_h(ctr), .crc_ovn_err_h(ovn),
    .crc_mb_tmo_h(tmo), .crc_busy_h(busy));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: channel in service, clocks since grant, ack seen
  int m_ctr [NCH];
  bit m_ovn [NCH];
  bit m_tmo, m_acked;
  int m_ptr, m_ch, m_age;

  function automatic bit m_ram();
    return (m_ch >= 0) && !m_acked && (m_age < RAMCYC);
  endfunction
  function automatic bit m_mb();
    return (m_ch >= 0) && !m_acked && (m_age >= RAMCYC);
  endfunction

  task automatic model_step();
    int dec_ch;
    bit tset;
    bit s;
    dec_ch = -1;
    tset   = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin m_ctr[i] = 0; m_ovn[i] = 1'b0; end
      m_tmo = 1'b0; m_ptr = NCH - 1; m_ch = -1; m_age = 0; m_acked = 1'b0;
      return;
    end
    if (m_ch < 0) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (req[c] && m_ctr[c] != 0) begin
          m_ch = c; m_age = 0; m_acked = 1'b0;
          break;
        end
      end
    end else if (m_acked) begin
      dec_ch = m_ch; m_ptr = m_ch; m_ch = -1;
    end else if (m_age < RAMCYC) begin
      m_age++;
    end else if (!t2_l) begin
      m_acked = 1'b1;
    end else if (m_age - RAMCYC == MBTMO - 1) begin
      tset = 1'b1; m_ch = -1;
    end else begin
      m_age++;
    end
    for (int i = 0; i < NCH; i++) begin
      s = 1'b0;
      if (inc[i] && i != dec_ch) begin
        if (m_ctr[i] == CMAX) s = 1'b1;
        else m_ctr[i]++;
      end else if (!inc[i] && i == dec_ch) begin
        m_ctr[i]--;
      end
      m_ovn[i] = clr ? s : (m_ovn[i] | s);
    end
    m_tmo = clr ? tset : (m_tmo | tset);
  endtask

  task automatic check_all();
    logic [63:0] ec, eo, eg;
    ec = '0; eo = '0; eg = '0;
    for (int i = 0; i < NCH; i++) begin
      ec |= 64'(m_ctr[i]) << (i * CTRW);
      eo[i] = m_ovn[i];
    end
    if (m_ch >= 0) eg[m_ch] = 1'b1;
    chk("model_grant", 64'(grant), eg);
    chk("model_ram_l", 64'(ram_l), 64'(!m_ram()));
    chk("model_mb", 64'(mb), 64'(m_mb()));
    chk("model_store_l", 64'(store_l), 64'(m_mb() ? !store[m_ch] : 1'b1));
    chk("model_ctr", 64'(ctr), ec);
    chk("model_ovn", 64'(ovn), eo);
    chk("model_tmo", 64'(tmo), 64'(m_tmo));
    chk("model_busy", 64'(busy), 64'(m_ch >= 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; store = '0; inc = '0; clr = 1'b0; t2_l = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 99;
  endfunction

  typedef struct {
    logic           rst_n;
    logic [NCH-1:0] req, inc;
    logic           t2_l;
    logic [NCH-1:0] e_grant;
    logic           e_ram_l, e_mb, e_busy;
    int             e_ctr2;
  } vec_t;

  vec_t tv [7];
  int   ord [$];
  int   exp_ord [3];
  logic [NCH-1:0] prev;
  int   mbn;
  bit   hit;

  initial begin
    rst_n = 1'b0; req = '0; store = '0; inc = '0; clr = 1'b0; t2_l = 1'b1;
    exp_ord = '{0, 3, 5};
    //            rst   req    inc    t2    grant   ram_l mb  busy ctr2
    tv[0] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    tv[1] = '{1'b1, 8'h00, 8'h04, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    tv[2] = '{1'b1, 8'h04, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1};
    tv[3] = '{1'b1, 8'h04, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1};
    tv[4] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 1};
    tv[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1};
    tv[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0};

    // Single-channel grant, RAM/MB timing and decrement
    for (int r = 0; r < 7; r++) begin
      rst_n = tv[r].rst_n; req = tv[r].req; inc = tv[r].inc; t2_l = tv[r].t2_l;
      tick();
      chk($sformatf("t1_grant[%0d]", r), 64'(grant), 64'(tv[r].e_grant));
      chk($sformatf("t1_ram_l[%0d]", r), 64'(ram_l), 64'(tv[r].e_ram_l));
      chk($sformatf("t1_mb[%0d]", r), 64'(mb), 64'(tv[r].e_mb));
      chk($sformatf("t1_busy[%0d]", r), 64'(busy), 64'(tv[r].e_busy));
      chk($sformatf("t1_ctr2[%0d]", r), 64'(ctr[2*CTRW +: CTRW]), 64'(tv[r].e_ctr2));
    end

    // Round-robin order, twice
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      inc = 8'b0010_1001; tick(); inc = '0;
      req = 8'b0010_1001; t2_l = 1'b0;
      ord.delete(); prev = '0;
      for (int c = 0; c < 40 && ord.size() < 3; c++) begin
        tick();
        if (grant != '0 && prev == '0) ord.push_back(oh_idx(grant));
        prev = grant;
      end
      chk("rr_count", 64'(ord.size()), 64'd3);
      for (int i = 0; i < 3; i++)
        chk($sformatf("rr_order[%0d.%0d]", pass, i), 64'(i < ord.size() ? ord[i] : 99), 64'(exp_ord[i]));
      for (int c = 0; c < 20 && busy; c++) tick();
      chk("rr_idle", 64'(busy), 64'd0);
    end

    // Saturation and overflow flag, then inc+dec at full count
    do_reset();
    t2_l = 1'b0;
    inc = 8'h02;
    for (int i = 0; i < 8; i++) tick();
    inc = '0;
    chk("sat_ctr1", 64'(ctr[1*CTRW +: CTRW]), 64'(CMAX));
    chk("sat_ovn1", 64'(ovn[1]), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovn", 64'(ovn), 64'd0);
    req = 8'h02; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      hit = busy && !mb && ram_l;
    end
    chk("done_reached", 64'(hit), 64'd1);
    inc = 8'h02; req = '0; tick(); inc = '0;
    chk("incdec_ctr1", 64'(ctr[1*CTRW +: CTRW]), 64'(CMAX));
    chk("incdec_ovn1", 64'(ovn[1]), 64'd0);

    // MB acknowledge timeout
    do_reset();
    inc = 8'h10; tick(); inc = '0;
    req = 8'h10; t2_l = 1'b1; mbn = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (mb) begin mbn++; req = '0; end
      if (mbn > 0 && !busy) break;
    end
    chk("tmo_mb_clks", 64'(mbn), 64'(MBTMO));
    chk("tmo_flag", 64'(tmo), 64'd1);
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_ctr4", 64'(ctr[4*CTRW +: CTRW]), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("tmo_clr", 64'(tmo), 64'd0);

    // Store enable only during MB, then reset in the middle of MB
    do_reset();
    inc = 8'h40; tick(); inc = '0;
    req = 8'h40; store = 8'h40; t2_l = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("store_l_vs_mb", 64'(store_l), 64'(!mb));
      if (mb) t2_l = 1'b0;
    end
    inc = 8'h40; t2_l = 1'b1; tick(); inc = '0;
    for (int c = 0; c < 10 && !mb; c++) tick();
    chk("rst_in_mb", 64'(mb), 64'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ram_l", 64'(ram_l), 64'd1);
    chk("rst_mb", 64'(mb), 64'd0);
    chk("rst_store_l", 64'(store_l), 64'd1);
    chk("rst_ctr", 64'(ctr), 64'd0);
    chk("rst_flags", 64'({ovn, tmo}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    store = '0;

    // Requests with empty counters never grant
    do_reset();
    req = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("empty_busy", 64'(busy), 64'd0);
      chk("empty_grant", 64'(grant), 64'd0);
    end

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      req   = NCH'($urandom);
      store = NCH'($urandom);
      inc   = NCH'($urandom & $urandom & $urandom);
      clr   = ($urandom_range(0, 29) == 0);
      t2_l  = ($urandom_range(0, 5) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
